// File: rtl/drv_pkg.sv
// Shared definitions for the dut host driver.
// Contents: FSM state enum, cfg op encodings, result error bit indices.
package drv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CFG_WR = 3'd1,
    CFG_RD = 3'd2,
    LEN    = 3'd3,
    STREAM = 3'd4,
    DONE   = 3'd5
  } drv_state_e;

  localparam logic CFG_OP_WRITE = 1'b1;
  localparam logic CFG_OP_READ  = 1'b0;

  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_CFG     = 1;

endpackage

// File: rtl/drv_stream_ctr.sv
// Datapath for the STREAM phase of the host driver.
// Ports:
//   CLK, RST_N       clock, async active-low reset
//   clr              clear all counters (job accept)
//   seed, len        latched job seed / length
//   stream_act       FSM is in STREAM (idle counter only runs there)
//   din_fire         din method fired this cycle
//   dout_fire        dout method fired this cycle
//   dout_value       byte dequeued from the dut
//   din_value        generated byte: seed + sent (8-bit wrap)
//   sent_done        every byte of the job has been sent
//   recv_done        every byte of the job has been received
//   recv_last        this dout fire receives the final byte
//   timeout_hit      an idle STREAM cycle with the idle counter at TIMEOUT-1
//   recv, sum        received byte count and running checksum
module drv_stream_ctr #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clr,
  input  logic [7:0]       seed,
  input  logic [7:0]       len,
  input  logic             stream_act,
  input  logic             din_fire,
  input  logic             dout_fire,
  input  logic [7:0]       dout_value,
  output logic [7:0]       din_value,
  output logic             sent_done,
  output logic             recv_done,
  output logic             recv_last,
  output logic             timeout_hit,
  output logic [CNT_W-1:0] recv,
  output logic [CNT_W-1:0] sum
);

  localparam int IW = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);

  logic [7:0]       sent_q;
  logic [CNT_W-1:0] recv_q;
  logic [CNT_W-1:0] sum_q;
  logic [IW-1:0]    idle_q;
  logic             any_fire;

  assign any_fire    = din_fire || dout_fire;
  assign din_value   = seed + sent_q;
  assign sent_done   = (sent_q == len);
  assign recv_done   = (recv_q == CNT_W'(len));
  assign recv_last   = dout_fire && ((recv_q + CNT_W'(1)) == CNT_W'(len));
  // Counter starts at 0 on STREAM entry, so this trips on the TIMEOUT-th
  // consecutive idle cycle.
  assign timeout_hit = stream_act && !any_fire && (idle_q == IW'(TIMEOUT - 1));
  assign recv        = recv_q;
  assign sum         = sum_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sent_q <= '0;
      recv_q <= '0;
      sum_q  <= '0;
      idle_q <= '0;
    end else if (clr) begin
      sent_q <= '0;
      recv_q <= '0;
      sum_q  <= '0;
      idle_q <= '0;
    end else begin
      if (din_fire)
        sent_q <= sent_q + 8'd1;
      if (dout_fire) begin
        recv_q <= recv_q + CNT_W'(1);
        sum_q  <= sum_q + CNT_W'(dout_value);
      end
      if (any_fire)
        idle_q <= '0;
      else if (stream_act && !timeout_hit)
        idle_q <= idle_q + IW'(1);
    end
  end

endmodule

// File: rtl/dut_host_driver.sv
// Initiator-side transactor for the dut method interface. Accepts one job,
// writes cfg, programs the length, streams seed-incrementing bytes into din
// while draining dout, then pulses a result with count/checksum/errors.
// Optional feature macro: DRV_CFG_READBACK_EN (adds a cfg read-back check
// after the write; a mismatch sets res_err[1]).
// Ports:
//   CLK, RST_N                    clock, async active-low reset
//   cmd_valid/cmd_ready           job handshake; cmd_len/seed/cfg job fields
//   din_*/dout_*/len_*/cfg_*      method enable/ready pairs to the dut
//   res_valid                     one-cycle result pulse
//   res_count/res_sum/res_err     results, held until the next accept
module dut_host_driver
  import drv_pkg::*;
#(
  parameter logic [7:0] CFG_ADDR = 8'h00,
  parameter int         TIMEOUT  = 1024,
  parameter int         CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_len,
  input  logic [7:0]       cmd_seed,
  input  logic [31:0]      cmd_cfg,
  output logic [7:0]       din_value,
  output logic             din_en,
  input  logic             din_rdy,
  output logic             dout_en,
  input  logic [7:0]       dout_value,
  input  logic             dout_rdy,
  output logic [7:0]       len_value,
  output logic             len_en,
  input  logic             len_rdy,
  output logic [7:0]       cfg_address,
  output logic [31:0]      cfg_data_in,
  output logic             cfg_op,
  output logic             cfg_en,
  input  logic [31:0]      cfg_data_out,
  input  logic             cfg_rdy,
  output logic             res_valid,
  output logic [CNT_W-1:0] res_count,
  output logic [CNT_W-1:0] res_sum,
  output logic [1:0]       res_err
);

  drv_state_e  state, state_n;
  logic [7:0]  len_q, seed_q;
  logic [31:0] cfg_q;
  logic [1:0]  err_q;
  logic        accept, din_fire, dout_fire, stream_act;
  logic        sent_done, recv_done, recv_last, timeout_hit;
  logic        set_to, set_cfg_err;

  assign accept      = cmd_valid && cmd_ready;
  assign din_fire    = din_en && din_rdy;
  assign dout_fire   = dout_en && dout_rdy;
  assign cfg_address = CFG_ADDR;
  assign cfg_data_in = cfg_q;
  assign len_value   = len_q;
  assign res_err     = err_q;

`ifndef DRV_CFG_READBACK_EN
  // Read data only matters for the read-back check.
  logic unused_cfg_rd;
  assign unused_cfg_rd = ^cfg_data_out;
`endif

  drv_stream_ctr #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_ctr (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .clr        (accept),
    .seed       (seed_q),
    .len        (len_q),
    .stream_act (stream_act),
    .din_fire   (din_fire),
    .dout_fire  (dout_fire),
    .dout_value (dout_value),
    .din_value  (din_value),
    .sent_done  (sent_done),
    .recv_done  (recv_done),
    .recv_last  (recv_last),
    .timeout_hit(timeout_hit),
    .recv       (res_count),
    .sum        (res_sum)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      len_q  <= '0;
      seed_q <= '0;
      cfg_q  <= '0;
      err_q  <= '0;
    end else if (accept) begin
      len_q  <= cmd_len;
      seed_q <= cmd_seed;
      cfg_q  <= cmd_cfg;
      err_q  <= '0;
    end else begin
      if (set_to)      err_q[ERR_TIMEOUT] <= 1'b1;
      if (set_cfg_err) err_q[ERR_CFG]     <= 1'b1;
    end
  end

  // Every enable is gated by its own rdy so no method is ever requested
  // against a not-ready dut.
  always_comb begin
    state_n     = state;
    cmd_ready   = 1'b0;
    cfg_en      = 1'b0;
    cfg_op      = CFG_OP_WRITE;
    len_en      = 1'b0;
    din_en      = 1'b0;
    dout_en     = 1'b0;
    res_valid   = 1'b0;
    stream_act  = 1'b0;
    set_to      = 1'b0;
    set_cfg_err = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_n = CFG_WR;
      end
      CFG_WR: begin
        cfg_en = cfg_rdy;
`ifdef DRV_CFG_READBACK_EN
        if (cfg_rdy) state_n = CFG_RD;
`else
        if (cfg_rdy) state_n = LEN;
`endif
      end
`ifdef DRV_CFG_READBACK_EN
      CFG_RD: begin
        cfg_op = CFG_OP_READ;
        cfg_en = cfg_rdy;
        if (cfg_rdy) begin
          set_cfg_err = (cfg_data_out != cfg_q);
          state_n     = LEN;
        end
      end
`endif
      LEN: begin
        if (len_q == 8'd0) begin
          state_n = DONE;
        end else begin
          len_en = len_rdy;
          if (len_rdy) state_n = STREAM;
        end
      end
      STREAM: begin
        stream_act = 1'b1;
        din_en     = din_rdy && !sent_done;
        dout_en    = dout_rdy && !recv_done;
        if (recv_last) begin
          state_n = DONE;
        end else if (timeout_hit) begin
          set_to  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
